// File: rtl/lif_neuron_scheduler.sv
// LIF neuron scheduler: one shared membrane-update datapath swept over
// NUM_NEURONS virtual neurons per timestep. Input arrives over a req/valid
// handshake from the synapse accumulator; spikes leave over valid/ready.
module lif_neuron_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 8,
    parameter int LEAK_SHIFT  = 3,
    parameter int THRESH_RST  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_start,
    input  logic              clear_state,
    input  logic              cfg_thresh_we,
    input  logic [DATA_W-1:0] cfg_thresh,
    output logic              syn_req,
    output logic [IDX_W-1:0]  syn_idx,
    input  logic              syn_valid,
    input  logic [DATA_W-1:0] syn_data,
    output logic              spk_valid,
    output logic [IDX_W-1:0]  spk_idx,
    input  logic              spk_ready,
    output logic              busy,
    output logic              step_done
);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t                 state_reg;
    logic [DATA_W-1:0]      mem_reg [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spk_flag_reg;
    logic [DATA_W-1:0]      thresh_reg;
    logic [IDX_W-1:0]       idx_reg;

    logic [DATA_W-1:0]      leak_term;
    logic [DATA_W:0]        sum_wide;
    logic [DATA_W-1:0]      sum_sat;
    logic                   fire;
    logic                   last_idx;
    logic [IDX_W-1:0]       idx_inc;

    // Membrane update for the current neuron: a neuron that fired last sweep
    // restarts from its fresh input (no carried leak term).
    always_comb begin
        leak_term = spk_flag_reg[idx_reg] ? '0 : (mem_reg[idx_reg] >> LEAK_SHIFT);
        sum_wide  = {1'b0, syn_data} + {1'b0, leak_term};
        sum_sat   = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
        fire      = (sum_sat >= thresh_reg);
        last_idx  = (idx_reg == IDX_W'(NUM_NEURONS - 1));
        idx_inc   = idx_reg + IDX_W'(1);
    end

    // Sweep FSM with neuron storage and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_reg[i] <= '0;
            end
            spk_flag_reg <= '0;
            thresh_reg   <= DATA_W'(THRESH_RST);
            idx_reg      <= '0;
            syn_req      <= 1'b0;
            syn_idx      <= '0;
            spk_valid    <= 1'b0;
            spk_idx      <= '0;
            busy         <= 1'b0;
            step_done    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    step_done <= 1'b0;
                    if (clear_state) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            mem_reg[i] <= '0;
                        end
                        spk_flag_reg <= '0;
                    end else if (cfg_thresh_we) begin
                        thresh_reg <= cfg_thresh;
                    end else if (step_start) begin
                        idx_reg   <= '0;
                        syn_idx   <= '0;
                        syn_req   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (syn_valid) begin
                        mem_reg[idx_reg]      <= sum_sat;
                        spk_flag_reg[idx_reg] <= fire;
                        if (fire) begin
                            syn_req   <= 1'b0;
                            spk_valid <= 1'b1;
                            spk_idx   <= idx_reg;
                            state_reg <= EMIT;
                        end else if (last_idx) begin
                            syn_req   <= 1'b0;
                            step_done <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg <= idx_inc;
                            syn_idx <= idx_inc;
                        end
                    end
                end
                EMIT: begin
                    if (spk_ready) begin
                        spk_valid <= 1'b0;
                        if (last_idx) begin
                            step_done <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_inc;
                            syn_idx   <= idx_inc;
                            syn_req   <= 1'b1;
                            state_reg <= FETCH;
                        end
                    end
                end
                DONE: begin
                    step_done <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
